// File: rtl/mem_stage_if.sv
// Bundles the MEM-stage request, data-memory and writeback signals.
// The slave modport is the stage's view and the master modport is the EX/memory side's view.
interface mem_stage_if #(
    parameter int unsigned REG_IDX_W = 3
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [7:0]           req_addr;
    logic [7:0]           req_data;
    logic [REG_IDX_W-1:0] req_rd_idx;
    logic                 flush;
    logic                 mem_we;
    logic                 mem_re;
    logic [7:0]           mem_a;
    logic [7:0]           mem_wd;
    logic [7:0]           mem_rd;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd_idx;
    logic [7:0]           wb_data;
    logic                 stall;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_rd_idx, flush, mem_rd,
        output req_ready, mem_we, mem_re, mem_a, mem_wd, wb_valid, wb_rd_idx, wb_data, stall
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, req_rd_idx, flush, mem_rd,
        input  req_ready, mem_we, mem_re, mem_a, mem_wd, wb_valid, wb_rd_idx, wb_data, stall
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: stores complete in the transfer cycle, PASS writes back one cycle later,
// and LOAD writes back two cycles later through a one-cycle LOAD_WAIT state.
module mem_stage #(
    parameter int unsigned REG_IDX_W = 3
) (
    input logic       Clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {OpNop, OpLoad, OpStore, OpPass} op_e;
    typedef enum logic {StIdle, StLoadWait} state_e;

    state_e               state_q, state_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [7:0]           wb_data_q, wb_data_d;
    logic [REG_IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [REG_IDX_W-1:0] ld_idx_q, ld_idx_d;
    logic                 ready;
    logic                 accept;

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_idx_d   = wb_idx_q;
        ld_idx_d   = ld_idx_q;

        ready  = (state_q == StIdle) && !rst;
        // A flushed transfer is still consumed but has no side effects.
        accept = bus.req_valid && ready && !bus.flush;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.req_op)
                        OpPass: begin
                            wb_valid_d = 1'b1;
                            wb_data_d  = bus.req_data;
                            wb_idx_d   = bus.req_rd_idx;
                        end
                        OpLoad: begin
                            ld_idx_d = bus.req_rd_idx;
                            state_d  = StLoadWait;
                        end
                        default: ;
                    endcase
                end
            end
            StLoadWait: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = bus.mem_rd;
                    wb_idx_d   = ld_idx_q;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_idx_q   <= '0;
            ld_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_idx_q   <= wb_idx_d;
            ld_idx_q   <= ld_idx_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.stall     = !ready;
    assign bus.mem_we    = accept && (bus.req_op == OpStore);
    assign bus.mem_re    = accept && (bus.req_op == OpLoad);
    assign bus.mem_a     = bus.req_addr;
    assign bus.mem_wd    = bus.req_data;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd_idx = wb_idx_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage; a retirement-queue model predicts every output.
module tb_mem_stage;
    logic Clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   load_acc = -100;

    typedef struct {
        int         due;
        logic [2:0] idx;
        logic [7:0] data;
    } entry_t;

    entry_t     q[$];
    logic [7:0] ref_mem[256];
    logic [7:0] tb_mem[256];
    logic [7:0] exp_data = 8'h00;
    logic [2:0] exp_idx = 3'h0;
    logic       exp_valid = 1'b0;

    mem_stage_if #(.REG_IDX_W(3)) bus ();

    mem_stage #(.REG_IDX_W(3)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory: read data is valid only the cycle after mem_re, garbage otherwise.
    always @(posedge Clk) begin
        if (bus.mem_re) bus.mem_rd <= tb_mem[bus.mem_a];
        else bus.mem_rd <= 8'($urandom);
        if (bus.mem_we) tb_mem[bus.mem_a] <= bus.mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] d, input logic [2:0] idx, input logic fl,
                        input logic r);
        logic   busy, rdy, acc;
        entry_t e;
        @(negedge Clk);
        rst            = r;
        bus.req_valid  = v;
        bus.req_op     = op;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_rd_idx = idx;
        bus.flush      = fl;
        #1;
        busy = (load_acc == cyc - 1);
        rdy  = !r && !busy;
        acc  = v && rdy && !fl;
        chk("req_ready", bus.req_ready, rdy);
        chk("stall", bus.stall, !rdy);
        chk("mem_we", bus.mem_we, acc && (op == 2'd2));
        chk("mem_re", bus.mem_re, acc && (op == 2'd1));
        chk("mem_a", bus.mem_a, a);
        chk("mem_wd", bus.mem_wd, d);
        if (r) begin
            q.delete();
            exp_data = 8'h00;
            exp_idx  = 3'h0;
            load_acc = -100;
        end else begin
            if (busy && fl) begin
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].due == cyc + 1) q.delete(i);
            end
            if (acc) begin
                case (op)
                    2'd1: begin
                        q.push_back('{due: cyc + 2, idx: idx, data: ref_mem[a]});
                        load_acc = cyc;
                    end
                    2'd2: ref_mem[a] = d;
                    2'd3: q.push_back('{due: cyc + 1, idx: idx, data: d});
                    default: ;
                endcase
            end
        end
        @(posedge Clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e         = q.pop_front();
            exp_valid = 1'b1;
            exp_data  = e.data;
            exp_idx   = e.idx;
        end
        chk("wb_valid", bus.wb_valid, exp_valid);
        chk("wb_data", bus.wb_data, exp_data);
        chk("wb_rd_idx", bus.wb_rd_idx, exp_idx);
    endtask

    initial begin
        logic [7:0] init_v;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_addr   = 8'h00;
        bus.req_data   = 8'h00;
        bus.req_rd_idx = 3'h0;
        bus.flush      = 1'b0;
        bus.mem_rd     = 8'h00;
        for (int i = 0; i < 256; i++) begin
            init_v     = 8'($urandom);
            ref_mem[i] = init_v;
            tb_mem[i]  = init_v;
        end

        // Reset
        repeat (3) step(1'b1, 2'd3, 8'h55, 8'h66, 3'h5, 1'b0, 1'b1);
        chk("rst_wb_data", bus.wb_data, 8'h00);

        // STORE 0x10 <= 0xA5, then LOAD it to r3
        step(1'b1, 2'd2, 8'h10, 8'hA5, 3'h0, 1'b0, 1'b0);
        chk("st_no_wb", bus.wb_valid, 1'b0);
        step(1'b1, 2'd1, 8'h10, 8'h00, 3'h3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h10, 8'h00, 3'h0, 1'b0, 1'b0);
        chk("ld_wb_data", bus.wb_data, 8'hA5);
        chk("ld_wb_idx", bus.wb_rd_idx, 3'h3);

        // Back-to-back PASS
        step(1'b1, 2'd3, 8'h00, 8'h11, 3'h1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 8'h00, 8'h22, 3'h2, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b0, 1'b0);
        chk("pass2_data", bus.wb_data, 8'h22);

        // LOAD then PASS held valid through the stall; then STORE to loaded address after wait
        step(1'b1, 2'd1, 8'h10, 8'h00, 3'h4, 1'b0, 1'b0);
        step(1'b1, 2'd3, 8'h00, 8'h33, 3'h6, 1'b0, 1'b0);
        step(1'b1, 2'd3, 8'h00, 8'h33, 3'h6, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 8'h10, 8'h00, 3'h5, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h10, 8'h00, 3'h0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 8'h10, 8'h5A, 3'h0, 1'b0, 1'b0);
        chk("ld_before_st", bus.wb_data, 8'hA5);

        // Flush in LOAD_WAIT, flush in IDLE
        step(1'b1, 2'd1, 8'h10, 8'h00, 3'h7, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b1, 1'b0);
        step(1'b1, 2'd3, 8'h00, 8'h44, 3'h2, 1'b1, 1'b0);
        step(1'b1, 2'd2, 8'h20, 8'h44, 3'h2, 1'b1, 1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b0, 1'b0);

        // Reset in LOAD_WAIT
        step(1'b1, 2'd1, 8'h10, 8'h00, 3'h1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 2'd0, 8'h00, 8'h00, 3'h0, 1'b0, 1'b0);

        // Random traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(3) != 0, 2'($urandom_range(3)), 8'($urandom_range(15)),
                 8'($urandom), 3'($urandom_range(7)), $urandom_range(9) == 0,
                 $urandom_range(49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter REG_IDX_W, default 3: width of the destination-register index.
REQ-002 Port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port req_valid, input, 1: EX stage presents a request.
REQ-005 Port req_ready, output, 1: stage accepts a request this cycle; transfer = req_valid & req_ready.
REQ-006 Port req_op, input, 2: operation code; 00 NOP, 01 LOAD, 10 STORE, 11 PASS.
REQ-007 Port req_addr, input, 8: memory address for LOAD/STORE.
REQ-008 Port req_data, input, 8: store data for STORE; ALU result for PASS.
REQ-009 Port req_rd_idx, input, REG_IDX_W: destination register for LOAD/PASS.
REQ-010 Port flush, input, 1: squash the in-flight load.
REQ-011 Port mem_we, output, 1: data memory write enable.
REQ-012 Port mem_re, output, 1: data memory read enable.
REQ-013 Port mem_a, output, 8: data memory address.
REQ-014 Port mem_wd, output, 8: data memory write data.
REQ-015 Port mem_rd, input, 8: data memory read data, valid one cycle after mem_re.
REQ-016 Port wb_valid, output, 1: writeback result valid, single-cycle pulse per result.
REQ-017 Port wb_rd_idx, output, REG_IDX_W: writeback destination register.
REQ-018 Port wb_data, output, 8: writeback data.
REQ-019 Port stall, output, 1: upstream hold request; equals ~req_ready.

Function
REQ-020 The FSM SHALL have two states: IDLE and LOAD_WAIT.
REQ-021 req_ready SHALL be 1 in IDLE and 0 in LOAD_WAIT.
REQ-022 mem_we, mem_re, mem_a and mem_wd SHALL be combinational from the request: mem_a = req_addr; mem_wd = req_data.
REQ-023 mem_we SHALL be 1 only when a STORE transfers; mem_re SHALL be 1 only when a LOAD transfers.
REQ-024 An accepted STORE SHALL complete in its transfer cycle, with no writeback and no state change.
REQ-025 An accepted PASS SHALL produce wb_valid=1, wb_data=req_data and wb_rd_idx=req_rd_idx in the next cycle.
REQ-026 An accepted LOAD SHALL capture req_rd_idx internally and move the FSM to LOAD_WAIT.
REQ-027 In LOAD_WAIT the stage SHALL register mem_rd into wb_data, assert wb_valid in the next cycle, and return to IDLE, giving LOAD latency = 2 cycles from transfer to wb_valid.
REQ-028 A NOP, or req_valid=0, SHALL cause no memory access and no writeback.
REQ-029 wb_valid SHALL be high for exactly one cycle per LOAD/PASS; wb_data and wb_rd_idx SHALL hold their last values while wb_valid=0.
REQ-030 Results SHALL retire in acceptance order; a request can never be accepted in LOAD_WAIT.
REQ-031 A request presented in the cycle after LOAD_WAIT (IDLE again) SHALL be accepted; a STORE there to the loaded address SHALL NOT change the already-captured load data.
REQ-032 flush asserted in LOAD_WAIT SHALL return the FSM to IDLE and suppress that load's wb_valid.
REQ-033 flush asserted in IDLE SHALL suppress the wb_valid that an accepted LOAD or PASS would otherwise produce, and SHALL suppress mem_we/mem_re that cycle.

Reset
REQ-034 While rst=1 the stage SHALL hold: state IDLE, wb_valid=0, wb_data=0, wb_rd_idx=0, mem_we=0, mem_re=0, req_ready=0.
REQ-035 Reset asserted in LOAD_WAIT SHALL abort the load, with no wb_valid afterward.
REQ-036 In the first cycle after rst deasserts, req_ready SHALL be 1.

Verification
REQ-037 STORE addr=0x10 data=0xA5 -> mem_we=1, mem_a=0x10, mem_wd=0xA5 in the same cycle; no wb_valid.
REQ-038 LOAD addr=0x10 rd=3 with mem_rd=0xA5 at T+1 -> stall=1 at T+1; wb_valid=1, wb_data=0xA5, wb_rd_idx=3 at T+2.
REQ-039 Back-to-back PASS 0x11 rd=1 then PASS 0x22 rd=2 -> wb pulses on consecutive cycles, in order; req_ready stays 1.
REQ-040 LOAD immediately followed by PASS held valid -> PASS stalled one cycle; LOAD wb precedes PASS wb.
REQ-041 LOAD, then flush=1 in LOAD_WAIT -> no wb_valid; req_ready=1 the next cycle.
REQ-042 rst=1 in LOAD_WAIT -> all outputs at reset values next cycle; no wb_valid after release.
